branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 82 ++++++++
 tb/tb_branch_predictor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry branch target buffer with 2-bit saturating direction
// counters, a combinational EX-stage mispredict flag and branch/mispredict counters.
module branch_predictor (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);
    localparam int ENTRIES = 16;

    // upd_valid qualifies every upd_* field for exactly one cycle. There is no
    // ready: the table accepts an update on every cycle upd_valid is high.
    logic        valid_q  [ENTRIES];
    logic [25:0] tag_q    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    logic [3:0] rd_idx;
    logic [3:0] wr_idx;
    logic       rd_hit;
    logic       wr_hit;

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign rd_idx      = if_pc[5:2];
    assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == if_pc[31:6]);
    assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
    assign pred_target = pred_taken ? target_q[rd_idx] : 32'h0;

    assign wr_idx = upd_pc[5:2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == upd_pc[31:6]);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= 26'h0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b01;
            end
            branch_count_q     <= 32'h0;
            mispredict_count_q <= 32'h0;
        end else begin
            if (upd_valid) begin
                branch_count_q <= branch_count_q + 32'd1;
                if (wr_hit) begin
                    if (upd_taken) begin
                        if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
                        target_q[wr_idx] <= upd_target;
                    end else if (ctr_q[wr_idx] != 2'b00) begin
                        ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
                    end
                end else if (upd_taken) begin
                    // A taken miss claims the slot, evicting whatever aliased there.
                    valid_q[wr_idx]  <= 1'b1;
                    tag_q[wr_idx]    <= upd_pc[31:6];
                    target_q[wr_idx] <= upd_target;
                    ctr_q[wr_idx]    <= 2'b10;
                end
            end
            if (mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, counter saturation,
// aliasing, same-cycle lookup/update, mid-run reset and counter wrap.
module tb_branch_predictor;
    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic clock_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic ptaken, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
        #1;
    endtask

    task automatic drive_idle();
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_pc = 32'h0;
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL reset_mispredict_comb: got %b want 1", mispredict); end
        clock_step();
        clock_step();
        rst = 1'b0;
        drive_idle();
        look(32'h100);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
        total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL reset_pred_target: got %h want 0", pred_target); end
        total++; if (branch_count !== 32'h0) begin bad++; $display("FAIL reset_branch_count: got %h want 0", branch_count); end
        total++; if (mispredict_count !== 32'h0) begin bad++; $display("FAIL reset_mispredict_count: got %h want 0", mispredict_count); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL idle_mispredict: got %b want 0", mispredict); end
    endtask

    task automatic test_allocate();
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mispredict: got %b want 1", mispredict); end
        clock_step();
        drive_idle();
        look(32'h100);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_pred_taken: got %b want 1", pred_taken); end
        total++; if (pred_target !== 32'h200) begin bad++; $display("FAIL alloc_pred_target: got %h want 200", pred_target); end
        total++; if (branch_count !== 32'd1) begin bad++; $display("FAIL alloc_branch_count: got %0d want 1", branch_count); end
        total++; if (mispredict_count !== 32'd1) begin bad++; $display("FAIL alloc_mispredict_count: got %0d want 1", mispredict_count); end
    endtask

    task automatic test_counter();
        look(32'h100);
        // 10 -> 01 (predicted taken, went not-taken: mispredict)
        drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL ctr_nt_mispredict: got %b want 1", mispredict); end
        clock_step();
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_01_pred: got %b want 0", pred_taken); end
        // 01 -> 00
        drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL ctr_nt_correct: got %b want 0", mispredict); end
        clock_step();
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_00_pred: got %b want 0", pred_taken); end
        // 00 -> 01, still not taken
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        clock_step();
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_00_to_01_pred: got %b want 0", pred_taken); end
        // 01 -> 10 -> 11 -> 11
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        clock_step();
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_10_pred: got %b want 1", pred_taken); end
        drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL ctr_taken_correct: got %b want 0", mispredict); end
        clock_step();
        drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        clock_step();
        // Saturated at 11, so one not-taken leaves it at 10 (still taken)
        drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        clock_step();
        drive_idle();
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_saturate_11: got %b want 1", pred_taken); end
        total++; if (pred_target !== 32'h200) begin bad++; $display("FAIL ctr_nt_keeps_target: got %h want 200", pred_target); end
        drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        clock_step();
        drive_idle();
        total++; if (branch_count !== 32'd9) begin bad++; $display("FAIL ctr_branch_count: got %0d want 9", branch_count); end
        total++; if (mispredict_count !== 32'd5) begin bad++; $display("FAIL ctr_mispredict_count: got %0d want 5", mispredict_count); end
    endtask

    task automatic test_alias();
        look(32'h140);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_lookup_taken: got %b want 0", pred_taken); end
        total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL alias_lookup_target: got %h want 0", pred_target); end
        drive_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
        clock_step();
        drive_idle();
        look(32'h100);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted: got %b want 0", pred_taken); end
        look(32'h143);
        total++; if (pred_target !== 32'h300) begin bad++; $display("FAIL alias_new_target: got %h want 300", pred_target); end
        // Not-taken miss at 0x100 must leave the 0x140 entry alone
        drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        clock_step();
        drive_idle();
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_nt_miss_unchanged: got %b want 1", pred_taken); end
        total++; if (branch_count !== 32'd11) begin bad++; $display("FAIL alias_branch_count: got %0d want 11", branch_count); end
        total++; if (mispredict_count !== 32'd6) begin bad++; $display("FAIL alias_mispredict_count: got %0d want 6", mispredict_count); end
    endtask

    task automatic test_same_cycle();
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        clock_step();
        look(32'h100);
        drive_upd(32'h100, 1'b1, 32'h204, 1'b1, 32'h200);
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL same_target_mismatch: got %b want 1", mispredict); end
        total++; if (pred_target !== 32'h200) begin bad++; $display("FAIL same_cycle_old_target: got %h want 200", pred_target); end
        clock_step();
        total++; if (pred_target !== 32'h204) begin bad++; $display("FAIL same_cycle_new_target: got %h want 204", pred_target); end
        drive_upd(32'h100, 1'b1, 32'h204, 1'b1, 32'h204);
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL same_target_match: got %b want 0", mispredict); end
        clock_step();
        upd_valid = 1'b0;
        upd_pred_taken = 1'b0;
        #1;
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL no_valid_no_mispredict: got %b want 0", mispredict); end
        drive_idle();
        total++; if (branch_count !== 32'd14) begin bad++; $display("FAIL same_branch_count: got %0d want 14", branch_count); end
        total++; if (mispredict_count !== 32'd8) begin bad++; $display("FAIL same_mispredict_count: got %0d want 8", mispredict_count); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        drive_upd(32'h180, 1'b1, 32'h500, 1'b0, 32'h0);
        clock_step();
        rst = 1'b0;
        drive_idle();
        look(32'h100);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_reset_cleared: got %b want 0", pred_taken); end
        look(32'h140);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_reset_cleared_140: got %b want 0", pred_taken); end
        look(32'h180);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_reset_discard: got %b want 0", pred_taken); end
        total++; if (branch_count !== 32'h0) begin bad++; $display("FAIL mid_reset_branch_count: got %h want 0", branch_count); end
        total++; if (mispredict_count !== 32'h0) begin bad++; $display("FAIL mid_reset_mispredict_count: got %h want 0", mispredict_count); end
    endtask

    task automatic test_wrap();
        force dut.branch_count_q = 32'hFFFF_FFFF;
        force dut.mispredict_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_count_q;
        release dut.mispredict_count_q;
        #1;
        total++; if (branch_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffffffff", branch_count); end
        drive_upd(32'h200, 1'b1, 32'h10, 1'b0, 32'h0);
        clock_step();
        total++; if (branch_count !== 32'h0) begin bad++; $display("FAIL wrap_branch_count: got %h want 0", branch_count); end
        total++; if (mispredict_count !== 32'h0) begin bad++; $display("FAIL wrap_mispredict_count: got %h want 0", mispredict_count); end
        drive_upd(32'h200, 1'b1, 32'h10, 1'b1, 32'h10);
        clock_step();
        drive_idle();
        total++; if (branch_count !== 32'd1) begin bad++; $display("FAIL wrap_then_count: got %0d want 1", branch_count); end
        total++; if (mispredict_count !== 32'h0) begin bad++; $display("FAIL wrap_then_mispredict: got %0d want 0", mispredict_count); end
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h0;
        drive_idle();
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_same_cycle();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
